// File: rtl/bnn_pkg.sv
// Shared constants, FSM encoding and BRAM address helper for the BNN input loader.
package bnn_pkg;

    localparam int IN_DATA_WIDTH = 28;
    localparam int IN_CHANNEL    = 3;
    localparam int PIX_WIDTH     = 8;
    localparam int IN_MEM_DWIDTH = IN_DATA_WIDTH;
    localparam int IN_MEM_AWIDTH = 7;
    localparam int IN_MEM_DEPTH  = IN_CHANNEL * IN_DATA_WIDTH;
    localparam int COL_WIDTH     = $clog2(IN_DATA_WIDTH);
    localparam int CH_WIDTH      = $clog2(IN_CHANNEL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Word address of a row: channel-major, one word per row.
    function automatic logic [IN_MEM_AWIDTH-1:0] word_addr_of(
        input logic [CH_WIDTH-1:0]  ch,
        input logic [COL_WIDTH-1:0] row
    );
        logic [IN_MEM_AWIDTH-1:0] addr;
        addr = IN_MEM_AWIDTH'(ch) * IN_MEM_AWIDTH'(IN_DATA_WIDTH) + IN_MEM_AWIDTH'(row);
        return addr;
    endfunction

endpackage

// File: rtl/bnn_row_packer.sv
// Binarizes accepted pixels into a row register and, on the last column,
// latches the finished word and its address into the BRAM holding register.
module bnn_row_packer
    import bnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     xfer,
    input  logic [PIX_WIDTH-1:0]     pixel,
    input  logic [PIX_WIDTH-1:0]     threshold,
    input  logic [COL_WIDTH-1:0]     col,
    input  logic [COL_WIDTH-1:0]     row,
    input  logic [CH_WIDTH-1:0]      ch,
    output logic                     word_we,
    output logic [IN_MEM_AWIDTH-1:0] word_addr,
    output logic [IN_MEM_DWIDTH-1:0] word_data
);

    logic                     pix_bit_s;
    logic                     last_col_s;
    logic [IN_MEM_DWIDTH-1:0] row_bits_r;
    logic [IN_MEM_DWIDTH-1:0] row_next_s;

    // Threshold compare and insertion of the current bit at its column.
    always_comb begin
        pix_bit_s       = (pixel >= threshold);
        last_col_s      = (col == COL_WIDTH'(IN_DATA_WIDTH - 1));
        row_next_s      = row_bits_r;
        row_next_s[col] = pix_bit_s;
    end

    // Row accumulation; the completed word goes to the holding register with a one-cycle write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_bits_r <= '0;
            word_we    <= 1'b0;
            word_addr  <= '0;
            word_data  <= '0;
        end else begin
            word_we <= 1'b0;
            if (clear) begin
                row_bits_r <= '0;
            end else if (xfer) begin
                if (last_col_s) begin
                    row_bits_r <= '0;
                    word_we    <= 1'b1;
                    word_addr  <= word_addr_of(ch, row);
                    word_data  <= row_next_s;
                end else begin
                    row_bits_r <= row_next_s;
                end
            end
        end
    end

endmodule

// File: rtl/bnn_input_loader.sv
// Frame loader: accepts a pixel stream, binarizes and packs it row by row,
// and writes each row word into the conv layer's input BRAM.
module bnn_input_loader
    import bnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_run,
    input  logic [PIX_WIDTH-1:0]     i_threshold,
    output logic                     o_idle,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [PIX_WIDTH-1:0]     s_data,
    input  logic                     s_last,
    output logic [IN_MEM_AWIDTH-1:0] addr_input,
    output logic                     ce_input,
    output logic                     we_input,
    output logic [IN_MEM_DWIDTH-1:0] d_input,
    input  logic [IN_MEM_DWIDTH-1:0] q_input
);

    state_t                   state_r;
    logic [PIX_WIDTH-1:0]     thr_r;
    logic [COL_WIDTH-1:0]     col_r;
    logic [COL_WIDTH-1:0]     row_r;
    logic [CH_WIDTH-1:0]      ch_r;
    logic                     xfer_s;
    logic                     start_s;
    logic                     col_last_s;
    logic                     row_last_s;
    logic                     final_pix_s;
    logic                     final_write_s;
    logic                     word_we_s;
    logic [IN_MEM_AWIDTH-1:0] word_addr_s;
    logic [IN_MEM_DWIDTH-1:0] word_data_s;
    logic                     unused_q_s;

    assign unused_q_s = ^q_input;

    // Handshake and end-of-frame decode.
    always_comb begin
        xfer_s        = s_valid & s_ready;
        start_s       = (state_r == S_IDLE) & i_run;
        col_last_s    = (col_r == COL_WIDTH'(IN_DATA_WIDTH - 1));
        row_last_s    = (row_r == COL_WIDTH'(IN_DATA_WIDTH - 1));
        final_pix_s   = col_last_s & row_last_s & (ch_r == CH_WIDTH'(IN_CHANNEL - 1));
        final_write_s = word_we_s & (word_addr_s == IN_MEM_AWIDTH'(IN_MEM_DEPTH - 1));
    end

    bnn_row_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_s),
        .xfer      (xfer_s),
        .pixel     (s_data),
        .threshold (thr_r),
        .col       (col_r),
        .row       (row_r),
        .ch        (ch_r),
        .word_we   (word_we_s),
        .word_addr (word_addr_s),
        .word_data (word_data_s)
    );

    assign ce_input   = word_we_s;
    assign we_input   = word_we_s;
    assign addr_input = word_addr_s;
    assign d_input    = word_data_s;

    // Frame FSM with counters, handshake ready and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            thr_r   <= '0;
            col_r   <= '0;
            row_r   <= '0;
            ch_r    <= '0;
            s_ready <= 1'b0;
            o_idle  <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_run) begin
                        state_r <= S_LOAD;
                        thr_r   <= i_threshold;
                        col_r   <= '0;
                        row_r   <= '0;
                        ch_r    <= '0;
                        o_err   <= 1'b0;
                        s_ready <= 1'b1;
                        o_idle  <= 1'b0;
                        o_busy  <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        s_ready <= 1'b0;
                        o_idle  <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (xfer_s) begin
                        if (col_last_s) begin
                            col_r <= '0;
                            if (row_last_s) begin
                                row_r <= '0;
                                ch_r  <= ch_r + CH_WIDTH'(1);
                            end else begin
                                row_r <= row_r + COL_WIDTH'(1);
                            end
                        end else begin
                            col_r <= col_r + COL_WIDTH'(1);
                        end
                        // s_last only flags framing errors; completion is purely count-based.
                        if (s_last != final_pix_s) begin
                            o_err <= 1'b1;
                        end
                        if (final_pix_s) begin
                            s_ready <= 1'b0;
                        end
                    end
                    if (final_write_s) begin
                        state_r <= S_DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    s_ready <= 1'b0;
                    o_done  <= 1'b0;
                    o_idle  <= 1'b1;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    s_ready <= 1'b0;
                    o_done  <= 1'b0;
                    o_idle  <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_input_loader.sv
// Directed testbench for bnn_input_loader: frame loads, threshold edge,
// stalls, s_last errors, mid-load reset and back-to-back frames.
module tb_bnn_input_loader;

    localparam int W     = 28;
    localparam int DEPTH = 84;
    localparam int TOTAL = 2352;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_run;
    logic [7:0]  i_threshold;
    logic        o_idle, o_busy, o_done, o_err;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_data;
    logic [6:0]  addr_input;
    logic        ce_input, we_input;
    logic [27:0] d_input, q_input;

    int num_cmp = 0;
    int num_bad = 0;
    int cyc = 0;
    int strobe_bad = 0;
    logic [27:0] mem [0:DEPTH-1];
    int wr_log[$];

    bnn_input_loader dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_threshold(i_threshold),
        .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .addr_input(addr_input), .ce_input(ce_input), .we_input(we_input),
        .d_input(d_input), .q_input(q_input)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model and write-order log, sampled away from the active edge.
    always @(negedge clk) begin
        if (ce_input !== we_input) strobe_bad++;
        if (we_input === 1'b1) begin
            wr_log.push_back(int'(addr_input));
            if (int'(addr_input) < DEPTH) mem[addr_input] = d_input;
        end
    end

    function automatic logic [7:0] pix_val(input int mode, input int idx);
        int col, row;
        col = idx % W;
        row = (idx / W) % W;
        if (mode == 0) return (((row + col) % 2) == 0) ? 8'd255 : 8'd0;
        else if (mode == 1) begin
            if (idx == 0) return 8'd99;
            else if (idx == 1) return 8'd100;
            else if (idx == 2) return 8'd101;
            else return 8'd0;
        end
        else return 8'd255;
    endfunction

    function automatic logic [27:0] exp_word(input int mode, input logic [7:0] thr, input int a);
        logic [27:0] w;
        w = '0;
        for (int c = 0; c < W; c++) w[c] = (pix_val(mode, a * W + c) >= thr);
        return w;
    endfunction

    task automatic clear_log();
        wr_log.delete();
        for (int i = 0; i < DEPTH; i++) mem[i] = 'x;
    endtask

    task automatic start_frame(input logic [7:0] thr);
        i_threshold = thr;
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
    endtask

    task automatic drive_frame(input int mode, input int gap_pct, input int last_idx,
                               input int first, input int stop, input int run_at,
                               output int last_cyc);
        int idx, guard;
        bit took;
        idx = first; guard = 0; last_cyc = -1;
        while (idx < stop && guard < 30000) begin
            s_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            s_data  = pix_val(mode, idx);
            s_last  = (idx == last_idx);
            i_run   = (idx == run_at);
            if (idx == run_at) i_threshold = 8'd0;
            took = s_valid && s_ready;
            if (took && idx == TOTAL - 1) last_cyc = cyc;
            @(negedge clk);
            guard++;
            if (took) idx++;
        end
        s_valid = 1'b0; s_last = 1'b0; i_run = 1'b0;
        num_cmp++;
        if (idx !== stop) begin
            num_bad++;
            $display("FAIL stream_stall: got %0d pixels, expected %0d", idx - first, stop - first);
        end
    endtask

    task automatic wait_done(input int bound, output int dcyc);
        bit seen;
        seen = 1'b0; dcyc = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin seen = 1'b1; dcyc = cyc; end
        end
        num_cmp++;
        if (!seen) begin
            num_bad++;
            $display("FAIL done_timeout: got no o_done, expected within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_run = 1'b0; i_threshold = 8'd0; s_valid = 1'b0;
        s_data = 8'd0; s_last = 1'b0; q_input = 28'd0;
        repeat (3) @(negedge clk);
        num_cmp++;
        if ({o_idle, o_busy, o_done, o_err, s_ready, ce_input, we_input} !== 7'b1000000) begin
            num_bad++;
            $display("FAIL reset_flags: got %b, expected 1000000",
                     {o_idle, o_busy, o_done, o_err, s_ready, ce_input, we_input});
        end
        num_cmp++;
        if ({addr_input, d_input} !== 35'd0) begin
            num_bad++;
            $display("FAIL reset_bram: got %0h/%0h, expected 0/0", addr_input, d_input);
        end
        reset = 1'b0;
        @(negedge clk);
        num_cmp++;
        if (o_idle !== 1'b1 || s_ready !== 1'b0) begin
            num_bad++;
            $display("FAIL idle_hold: got idle=%b ready=%b, expected 1/0", o_idle, s_ready);
        end
    endtask

    task automatic test_checker();
        int lc, dc;
        clear_log();
        start_frame(8'd128);
        num_cmp++;
        if ({o_idle, o_busy, s_ready} !== 3'b011) begin
            num_bad++;
            $display("FAIL start_flags: got %b, expected 011", {o_idle, o_busy, s_ready});
        end
        drive_frame(0, 0, TOTAL - 1, 0, TOTAL, -1, lc);
        wait_done(20, dc);
        num_cmp++;
        if (dc - lc !== 2) begin
            num_bad++;
            $display("FAIL done_latency: got %0d, expected 2", dc - lc);
        end
        num_cmp++;
        if (wr_log.size() !== DEPTH) begin
            num_bad++;
            $display("FAIL write_count: got %0d, expected %0d", wr_log.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            num_cmp++;
            if (((i < wr_log.size()) ? wr_log[i] : -1) !== i) begin
                num_bad++;
                $display("FAIL write_order[%0d]: got %0d, expected %0d", i,
                         (i < wr_log.size()) ? wr_log[i] : -1, i);
            end
            num_cmp++;
            if (mem[i] !== (((i % 2) == 0) ? 28'h5555555 : 28'hAAAAAAA)) begin
                num_bad++;
                $display("FAIL checker_word[%0d]: got %h, expected %h", i, mem[i],
                         ((i % 2) == 0) ? 28'h5555555 : 28'hAAAAAAA);
            end
        end
        num_cmp++;
        if (o_err !== 1'b0) begin
            num_bad++;
            $display("FAIL checker_err: got %b, expected 0", o_err);
        end
        @(negedge clk);
        num_cmp++;
        if ({o_done, o_idle, s_ready} !== 3'b010) begin
            num_bad++;
            $display("FAIL done_pulse: got %b, expected 010", {o_done, o_idle, s_ready});
        end
    endtask

    task automatic test_threshold();
        int lc, dc;
        clear_log();
        start_frame(8'd100);
        drive_frame(1, 0, TOTAL - 1, 0, TOTAL, -1, lc);
        wait_done(20, dc);
        num_cmp++;
        if (mem[0] !== 28'h0000006) begin
            num_bad++;
            $display("FAIL thr_word0: got %h, expected 0000006", mem[0]);
        end
        num_cmp++;
        if (mem[1] !== 28'h0 || mem[28] !== 28'h0) begin
            num_bad++;
            $display("FAIL thr_zero_rows: got %h/%h, expected 0/0", mem[1], mem[28]);
        end
        @(negedge clk);
    endtask

    task automatic test_gaps();
        int lc, dc;
        clear_log();
        start_frame(8'd128);
        drive_frame(0, 50, TOTAL - 1, 0, TOTAL, -1, lc);
        wait_done(20, dc);
        num_cmp++;
        if (dc - lc !== 2) begin
            num_bad++;
            $display("FAIL gap_latency: got %0d, expected 2", dc - lc);
        end
        num_cmp++;
        if (wr_log.size() !== DEPTH) begin
            num_bad++;
            $display("FAIL gap_count: got %0d, expected %0d", wr_log.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            num_cmp++;
            if (((i < wr_log.size()) ? wr_log[i] : -1) !== i || mem[i] !== exp_word(0, 8'd128, i)) begin
                num_bad++;
                $display("FAIL gap_word[%0d]: got addr %0d data %h, expected addr %0d data %h", i,
                         (i < wr_log.size()) ? wr_log[i] : -1, mem[i], i, exp_word(0, 8'd128, i));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_slast();
        int lc, dc;
        clear_log();
        start_frame(8'd128);
        drive_frame(0, 0, 100, 0, 100, -1, lc);
        num_cmp++;
        if (o_err !== 1'b0) begin
            num_bad++;
            $display("FAIL err_early: got %b, expected 0", o_err);
        end
        drive_frame(0, 0, 100, 100, 101, -1, lc);
        num_cmp++;
        if (o_err !== 1'b1) begin
            num_bad++;
            $display("FAIL err_set: got %b, expected 1", o_err);
        end
        drive_frame(0, 0, 100, 101, TOTAL, -1, lc);
        wait_done(20, dc);
        num_cmp++;
        if (wr_log.size() !== DEPTH || o_err !== 1'b1) begin
            num_bad++;
            $display("FAIL err_complete: got %0d writes err=%b, expected %0d writes err=1",
                     wr_log.size(), o_err, DEPTH);
        end
        @(negedge clk);
        start_frame(8'd128);
        num_cmp++;
        if (o_err !== 1'b0) begin
            num_bad++;
            $display("FAIL err_clear: got %b, expected 0", o_err);
        end
        drive_frame(0, 0, TOTAL - 1, 0, TOTAL, -1, lc);
        wait_done(20, dc);
        num_cmp++;
        if (o_err !== 1'b0) begin
            num_bad++;
            $display("FAIL err_clean_frame: got %b, expected 0", o_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lc, dc;
        clear_log();
        start_frame(8'd128);
        drive_frame(0, 0, TOTAL - 1, 0, 40, -1, lc);
        reset = 1'b1;
        @(negedge clk);
        wr_log.delete();
        num_cmp++;
        if ({o_idle, o_busy, o_done, o_err, s_ready, ce_input, we_input} !== 7'b1000000
            || {addr_input, d_input} !== 35'd0) begin
            num_bad++;
            $display("FAIL midreset_outputs: got %b %0h %0h, expected 1000000 0 0",
                     {o_idle, o_busy, o_done, o_err, s_ready, ce_input, we_input}, addr_input, d_input);
        end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        num_cmp++;
        if (wr_log.size() !== 0) begin
            num_bad++;
            $display("FAIL midreset_writes: got %0d, expected 0", wr_log.size());
        end
        clear_log();
        start_frame(8'd128);
        drive_frame(0, 0, TOTAL - 1, 0, TOTAL, -1, lc);
        wait_done(20, dc);
        num_cmp++;
        if (wr_log.size() !== DEPTH || wr_log[0] !== 0) begin
            num_bad++;
            $display("FAIL reload_order: got %0d writes first %0d, expected %0d first 0",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : -1, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            num_cmp++;
            if (mem[i] !== exp_word(0, 8'd128, i)) begin
                num_bad++;
                $display("FAIL reload_word[%0d]: got %h, expected %h", i, mem[i], exp_word(0, 8'd128, i));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lc, dc;
        clear_log();
        start_frame(8'd128);
        drive_frame(0, 0, TOTAL - 1, 0, TOTAL, 500, lc);
        wait_done(20, dc);
        for (int i = 0; i < DEPTH; i++) begin
            num_cmp++;
            if (mem[i] !== exp_word(0, 8'd128, i)) begin
                num_bad++;
                $display("FAIL midrun_word[%0d]: got %h, expected %h", i, mem[i], exp_word(0, 8'd128, i));
            end
        end
        i_threshold = 8'd255;
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        num_cmp++;
        if ({o_idle, o_busy, s_ready} !== 3'b100) begin
            num_bad++;
            $display("FAIL done_run_ignored: got %b, expected 100", {o_idle, o_busy, s_ready});
        end
        clear_log();
        start_frame(8'd200);
        drive_frame(2, 0, TOTAL - 1, 0, TOTAL, -1, lc);
        wait_done(20, dc);
        num_cmp++;
        if (wr_log.size() !== DEPTH || dc - lc !== 2) begin
            num_bad++;
            $display("FAIL frame2_count: got %0d writes latency %0d, expected %0d writes latency 2",
                     wr_log.size(), dc - lc, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            num_cmp++;
            if (((i < wr_log.size()) ? wr_log[i] : -1) !== i || mem[i] !== 28'hFFFFFFF) begin
                num_bad++;
                $display("FAIL frame2_word[%0d]: got addr %0d data %h, expected addr %0d data fffffff",
                         i, (i < wr_log.size()) ? wr_log[i] : -1, mem[i], i);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_checker();
        test_threshold();
        test_gaps();
        test_slast();
        test_reset_mid();
        test_back_to_back();
        num_cmp++;
        if (strobe_bad !== 0) begin
            num_bad++;
            $display("FAIL ce_we_match: got %0d differing cycles, expected 0", strobe_bad);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_bad);
        $finish;
    end

endmodule
